// File: rtl/jogo_pkg.sv
// Shared control-unit definitions: FSM state codes for the sequence
// display unit and the debug code shown for unused state encodings.
package jogo_pkg;

  typedef enum logic [3:0] {
    inicial    = 4'h0,
    preparacao = 4'h1,
    carrega    = 4'h2,
    acende     = 4'h3,
    apaga      = 4'h4,
    proximo    = 4'h5,
    fim_exibe  = 4'hA
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and count enable.
// fim is high while the count sits at M-1.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim
);

  localparam logic [N-1:0] MAXIMO = N'(M - 1);

  // Count register: clear has priority over enable, wraps after M-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Q <= '0;
    end else if (zera) begin
      Q <= '0;
    end else if (conta) begin
      if (Q == MAXIMO) Q <= '0;
      else             Q <= Q + 1'b1;
    end
  end

  // Terminal-count flag.
  always_comb begin
    fim = (Q == MAXIMO);
  end

endmodule

// File: rtl/controle_exibe_sequencia.sv
// Sequence display controller: walks memory addresses 0..limite, lighting
// each one-hot item on the LEDs for T_ACESO cycles.
// Optional macro EXIBE_INTERVALO_EN adds a dark gap of T_APAGADO cycles
// (state apaga) after every item; without it items follow back to back.
module controle_exibe_sequencia
  import jogo_pkg::*;
#(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mostrar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  // One timer serves both intervals; it is sized for the longer one so its
  // terminal flag marks the end of whichever interval is the longest.
  localparam int          M_TIMER     = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam logic [15:0] ULT_ACESO   = 16'(T_ACESO - 1);
  localparam logic [15:0] ULT_APAGADO = 16'(T_APAGADO - 1);

  estado_t     estado, estado_prox;
  logic [15:0] timer;
  logic        timer_fim, zera_timer, conta_timer;
  logic        fim_aceso, ultimo;
  logic [3:0]  limite_reg, item;

  contador_m #(.M(M_TIMER), .N(16)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timer),
    .conta (conta_timer),
    .Q     (timer),
    .fim   (timer_fim)
  );

  assign fim_aceso = (T_ACESO >= T_APAGADO) ? timer_fim : (timer == ULT_ACESO);
  assign ultimo    = (endereco == limite_reg);

`ifdef EXIBE_INTERVALO_EN
  logic fim_apagado;
  assign fim_apagado = (T_APAGADO >= T_ACESO) ? timer_fim : (timer == ULT_APAGADO);
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= inicial;
    else       estado <= estado_prox;
  end

  // Next-state logic; mostrar only matters when idle or finished.
  always_comb begin
    estado_prox = estado;
    case (estado)
      inicial:    if (mostrar) estado_prox = preparacao;
      preparacao: estado_prox = carrega;
      carrega:    estado_prox = acende;
`ifdef EXIBE_INTERVALO_EN
      acende:     if (fim_aceso) estado_prox = apaga;
      apaga:      if (fim_apagado) estado_prox = ultimo ? fim_exibe : proximo;
`else
      acende:     if (fim_aceso) estado_prox = ultimo ? fim_exibe : proximo;
`endif
      proximo:    estado_prox = carrega;
      fim_exibe:  if (mostrar) estado_prox = preparacao;
      default:    estado_prox = inicial;
    endcase
  end

  // Timer restarts on every state change and runs only while lit or dark.
  always_comb begin
    zera_timer  = (estado_prox != estado) || (estado == preparacao) || (estado == carrega);
    conta_timer = (estado == acende) || (estado == apaga);
  end

  // Address, latched limit and item register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= '0;
      limite_reg <= '0;
      item       <= '0;
    end else begin
      case (estado)
        preparacao: begin
          endereco   <= '0;
          limite_reg <= limite;
        end
        carrega: item     <= dado_mem;
        proximo: endereco <= endereco + 4'd1;
        default: ;
      endcase
    end
  end

  // Moore outputs and debug state code.
  always_comb begin
    leds      = '0;
    exibindo  = 1'b0;
    pronto    = 1'b0;
    db_estado = DB_INVALIDO;
    case (estado)
      inicial:    db_estado = inicial;
      preparacao: db_estado = preparacao;
      carrega: begin
        db_estado = carrega;
        exibindo  = 1'b1;
      end
      acende: begin
        db_estado = acende;
        exibindo  = 1'b1;
        leds      = item;
      end
`ifdef EXIBE_INTERVALO_EN
      apaga: begin
        db_estado = apaga;
        exibindo  = 1'b1;
      end
`endif
      proximo: begin
        db_estado = proximo;
        exibindo  = 1'b1;
      end
      fim_exibe: begin
        db_estado = fim_exibe;
        pronto    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_exibe_sequencia.sv
// Scoreboard bench for controle_exibe_sequencia (T_ACESO=4, T_APAGADO=2,
// memory holds 1,2,4,8 repeating). Honours EXIBE_INTERVALO_EN.
module tb_controle_exibe_sequencia;

  localparam int T_ACESO   = 4;
  localparam int T_APAGADO = 2;
`ifdef EXIBE_INTERVALO_EN
  localparam int GAP     = T_APAGADO;
  localparam int LAT_FIM = 24;
`else
  localparam int GAP     = 0;
  localparam int LAT_FIM = 18;
`endif

  logic       clock = 1'b0;
  logic       reset, mostrar;
  logic [3:0] limite, dado_mem, endereco, leds, db_estado;
  logic       exibindo, pronto;

  int total = 0;
  int bad   = 0;

  typedef logic [13:0] obs_t;  // {db_estado, leds, endereco, exibindo, pronto}
  obs_t       fila[$];
  logic [3:0] m_end;

  always #5 clock = ~clock;

  assign dado_mem = 4'b0001 << endereco[1:0];

  controle_exibe_sequencia #(.T_ACESO(T_ACESO), .T_APAGADO(T_APAGADO)) dut (
    .clock     (clock),
    .reset     (reset),
    .mostrar   (mostrar),
    .limite    (limite),
    .dado_mem  (dado_mem),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t obs(input logic [3:0] db, input logic [3:0] l,
                               input logic [3:0] e, input logic x, input logic p);
    return {db, l, e, x, p};
  endfunction

  // Expected per-cycle observation from preparacao through n_fim cycles of fim_exibe.
  task automatic push_seq(input logic [3:0] lim, input int n_fim);
    logic [3:0] it;
    fila.push_back(obs(4'h1, 4'h0, m_end, 1'b0, 1'b0));
    for (int i = 0; i <= int'(lim); i++) begin
      it = 4'b0001 << i[1:0];
      fila.push_back(obs(4'h2, 4'h0, 4'(i), 1'b1, 1'b0));
      for (int k = 0; k < T_ACESO; k++) fila.push_back(obs(4'h3, it, 4'(i), 1'b1, 1'b0));
      for (int k = 0; k < GAP; k++)     fila.push_back(obs(4'h4, 4'h0, 4'(i), 1'b1, 1'b0));
      if (i < int'(lim)) fila.push_back(obs(4'h5, 4'h0, 4'(i), 1'b1, 1'b0));
    end
    for (int k = 0; k < n_fim; k++) fila.push_back(obs(4'hA, 4'h0, lim, 1'b0, 1'b1));
    m_end = lim;
  endtask

  // Scoreboard comparator.
  always @(negedge clock) begin
    if (fila.size() > 0) begin
      obs_t e;
      e = fila.pop_front();
      check("trace", {18'd0, db_estado, leds, endereco, exibindo, pronto}, {18'd0, e});
    end
  end

  task automatic drain();
    int g;
    g = 0;
    while (fila.size() > 0 && g < 500) begin
      @(posedge clock);
      g++;
    end
    check("drain", fila.size(), 0);
    fila.delete();
    @(negedge clock);
  endtask

  task automatic pulse_run(input logic [3:0] lim, output int lat);
    @(negedge clock);
    limite  = lim;
    mostrar = 1'b1;
    @(posedge clock);
    #1 mostrar = 1'b0;
    push_seq(lim, 3);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (db_estado !== 4'hA && lat < 200);
    lat = lat - 1;
    drain();
  endtask

  initial begin
    int lat, g;
    reset = 1'b1; mostrar = 1'b0; limite = 4'd2; m_end = 4'd0;
    repeat (2) @(negedge clock);
    check("rst_db",   db_estado, 4'h0);
    check("rst_leds", leds, 4'h0);
    check("rst_end",  endereco, 4'h0);
    check("rst_exib", exibindo, 1'b0);
    check("rst_pronto", pronto, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_db", db_estado, 4'h0);

    // Three items from an idle start.
    pulse_run(4'd2, lat);
    check("lat_fim", lat, LAT_FIM);

    // Single item, endereco never advances.
    pulse_run(4'd0, lat);

    // mostrar held high, limite changed mid-display: replay with new limit.
    @(negedge clock);
    limite  = 4'd2;
    mostrar = 1'b1;
    @(posedge clock);
    #1;
    push_seq(4'd2, 1);
    push_seq(4'd5, 3);
    repeat (5) @(negedge clock);
    limite = 4'd5;
    repeat (30) @(negedge clock);
    mostrar = 1'b0;
    drain();

    // Asynchronous reset in the middle of the first item's lit phase.
    @(negedge clock);
    limite  = 4'd2;
    mostrar = 1'b1;
    @(posedge clock);
    #1 mostrar = 1'b0;
    g = 0;
    while (leds !== 4'h1 && g < 50) begin
      @(negedge clock);
      g++;
    end
    check("reach_acende", leds, 4'h1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_db",   db_estado, 4'h0);
    check("mid_rst_leds", leds, 4'h0);
    check("mid_rst_end",  endereco, 4'h0);
    check("mid_rst_exib", exibindo, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    m_end = 4'd0;
    repeat (8) @(negedge clock);
    check("post_rst_db",  db_estado, 4'h0);
    check("post_rst_end", endereco, 4'h0);

    // Recovery after reset.
    pulse_run(4'd1, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
